// File: rtl/posit_extract_pipe_if.sv
// Stream interface for the posit decoder:
// raw words in, unpacked value fields out.
interface posit_extract_pipe_if #(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int FBITS = NBITS-3-ES
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [7:0]       out_scale;
  logic [ES-1:0]    out_exponent;
  logic [FBITS-1:0] out_fraction;
  logic             out_inf;
  logic             out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_scale,
    input  out_exponent, out_fraction, out_inf, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_scale,
    output out_exponent, out_fraction, out_inf, out_zero
  );
endinterface

// File: rtl/posit_extract_pipe.sv
// Two-stage posit<NBITS,ES> decoder: stage 1 takes sign and magnitude,
// stage 2 decodes regime/exponent/fraction into the output register.
module posit_extract_pipe #(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int FBITS = NBITS-3-ES
) (
  input logic clk,
  input logic reset,
  posit_extract_pipe_if.slave bus
);
  localparam int MW = $clog2(NBITS) + 1;
  localparam int DROP = NBITS-1-ES-FBITS;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic             inf;
    logic [NBITS-2:0] mag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [7:0]       scale;
    logic [ES-1:0]    exp;
    logic [FBITS-1:0] frac;
    logic             inf;
    logic             zero;
  } s2_t;

  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.in_data[NBITS-1];
    s1_d.zero = (bus.in_data == '0);
    s1_d.inf  = (bus.in_data == {1'b1, {(NBITS-1){1'b0}}});
    s1_d.mag  = (NBITS-1)'(bus.in_data[NBITS-1] ?
                 (~bus.in_data + 1'b1) : bus.in_data);
  end

  logic [NBITS-2:0] body, sh;
  logic [NBITS-4:0] ef;
  logic [ES-1:0]    ex;
  logic [MW-1:0]    m;
  logic [7:0]       k;
  logic             r, run;

  always_comb begin
    body = s1_q.mag;
    r    = body[NBITS-2];
    m    = '0;
    run  = 1'b1;
    // Leading run of regime bits; m ends in 1..NBITS-1.
    for (int i = NBITS-2; i >= 0; i--) begin
      if (run && body[i] == r) m = m + MW'(1);
      else run = 1'b0;
    end
    sh = body << (m + MW'(1));
    ef = (NBITS-3)'(sh >> DROP);
    ex = ef[NBITS-4 -: ES];
    k  = r ? (8'(m) - 8'd1) : (8'd0 - 8'(m));
    s2_d      = '0;
    s2_d.zero = s1_q.zero;
    s2_d.inf  = s1_q.inf;
    if (!(s1_q.zero || s1_q.inf)) begin
      s2_d.sign  = s1_q.sign;
      s2_d.exp   = ex;
      s2_d.frac  = ef[FBITS-1:0];
      s2_d.scale = 8'(k << ES) + 8'(ex);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s2_d;
      end
    end
  end

  assign bus.out_valid    = s2_valid;
  assign bus.out_sign     = s2_q.sign;
  assign bus.out_scale    = s2_q.scale;
  assign bus.out_exponent = s2_q.exp;
  assign bus.out_fraction = s2_q.frac;
  assign bus.out_inf      = s2_q.inf;
  assign bus.out_zero     = s2_q.zero;
endmodule

// File: tb/tb_posit_extract_pipe.sv
// Directed bench for posit_extract_pipe: single decodes,
// streaming, backpressure and mid-flight reset.
module tb_posit_extract_pipe;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  posit_extract_pipe_if #(.NBITS(32), .ES(2)) bus();

  posit_extract_pipe #(.NBITS(32), .ES(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] vin [8];
  logic [39:0] vexp [8];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [39:0] pk(logic s, int sc, int e,
                                     int f, logic inf, logic z);
    return {s, 8'(sc), 2'(e), 27'(f), inf, z};
  endfunction

  function automatic logic [39:0] obs();
    return {bus.out_sign, bus.out_scale, bus.out_exponent,
            bus.out_fraction, bus.out_inf, bus.out_zero};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input int i);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = vin[i];
    chk($sformatf("rdy_%0d", i), 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk($sformatf("lat1_%0d", i), 64'(bus.out_valid), 64'd0);
    tick();
    chk($sformatf("lat2_%0d", i), 64'(bus.out_valid), 64'd1);
    chk($sformatf("val_%0d", i), 64'(obs()), 64'(vexp[i]));
    tick();
  endtask

  initial begin
    int got, first, last, sent, rcv, idx;
    int sidx [4];

    vin[0] = 32'h40000000; vexp[0] = pk(0, 0, 0, 0, 0, 0);
    vin[1] = 32'h4C000000; vexp[1] = pk(0, 1, 1, 'h4000000, 0, 0);
    vin[2] = 32'hC0000000; vexp[2] = pk(1, 0, 0, 0, 0, 0);
    vin[3] = 32'h7FFFFFFF; vexp[3] = pk(0, 120, 0, 0, 0, 0);
    vin[4] = 32'h00000001; vexp[4] = pk(0, -120, 0, 0, 0, 0);
    vin[5] = 32'h00000000; vexp[5] = pk(0, 0, 0, 0, 0, 1);
    vin[6] = 32'h80000000; vexp[6] = pk(0, 0, 0, 0, 1, 0);
    vin[7] = 32'h48000000; vexp[7] = pk(0, 1, 1, 0, 0, 0);

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_data", 64'(obs()), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) single(i);

    // back-to-back stream of 8 words
    got = 0; first = -1; last = -1; sent = 0;
    for (int c = 0; c < 30; c++) begin
      idx = (sent < 8) ? sent : 0;
      bus.out_ready = 1'b1;
      bus.in_valid  = (sent < 8);
      bus.in_data   = vin[idx];
      if (bus.out_valid) begin
        if (got < 8) chk($sformatf("stream_%0d", got),
                         64'(obs()), 64'(vexp[got]));
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (bus.in_valid) begin
        chk("stream_rdy", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) sent++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("stream_cnt", 64'(got), 64'd8);
    chk("stream_span", 64'(last - first), 64'd7);

    // backpressure: out_ready low for 5 cycles after first result
    sidx[0] = 0; sidx[1] = 1; sidx[2] = 2; sidx[3] = 7;
    rcv = 0; sent = 0; first = -1;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid && first < 0) first = c;
      bus.out_ready = !(first >= 0 && c < first + 5);
      idx = (sent < 4) ? sent : 0;
      bus.in_valid = (sent < 4);
      bus.in_data  = vin[sidx[idx]];
      #1;
      if (bus.out_valid) begin
        if (rcv >= 4) begin
          chk("stall_extra", 64'd1, 64'd0);
        end else if (!bus.out_ready) begin
          chk("stall_hold", 64'(obs()), 64'(vexp[sidx[rcv]]));
          chk("stall_rdy", 64'(bus.in_ready), 64'd0);
        end else begin
          chk($sformatf("stall_out_%0d", rcv),
              64'(obs()), 64'(vexp[sidx[rcv]]));
          rcv++;
        end
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("stall_rcv", 64'(rcv), 64'd4);
    chk("stall_sent", 64'(sent), 64'd4);

    // reset with two words in flight
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = vin[1];
    tick();
    bus.in_data = vin[2];
    tick();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_data", 64'(obs()), 64'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_idle", 64'(bus.out_valid), 64'd0);
    end
    single(7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/posit_extract_pipe.md
Name: posit_extract_pipe

Overview:
- Two-stage pipelined posit decoder for posit<NBITS,ES>.
- Sits directly upstream of the multiply/accumulate datapath and converts raw posit words into the unpacked `value` fields (sign, scale, exponent, fraction, inf, zero) that those stages consume.
- Uses a valid/ready stream handshake on both sides, so it can sit in the PairHMM posit stream under backpressure.

Parameters:
- NBITS, 32, posit word width
- ES, 2, exponent field width
- FBITS, NBITS-3-ES (=27), fraction width of the unpacked value, hidden bit excluded

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  decoder can accept a word this cycle
- in_data  in  NBITS  raw posit word
- out_valid  out  1  decoded value valid
- out_ready  in  1  downstream accepts value this cycle
- out_sign  out  1  sign of value
- out_scale  out  8  signed scale = k*2^ES + exponent
- out_exponent  out  ES  exponent field
- out_fraction  out  FBITS  fraction bits, MSB-aligned, no hidden bit
- out_inf  out  1  NaR (0x80000000)
- out_zero  out  1  zero (0x00000000)

Behaviour:
- Reset (async, active-high) clears both stage valid flags and all output data registers to 0. The block leaves reset with out_valid=0 and in_ready=1.
- Handshake:
  - A transfer occurs when valid&ready are both high on a clock edge.
  - Stage n advances when it is empty, or when stage n+1 advances or is empty.
  - in_ready = !s1_valid | s1_advance.
  - s2 is the output register; out_valid = s2_valid.
  - in_ready must not depend on in_valid.
  - Full throughput is 1 word/cycle. Latency is 2 cycles from input transfer to out_valid with out_ready held high.
- Stalls:
  - While out_valid=1 and out_ready=0, all outputs hold stable.
  - No word is dropped or duplicated.
  - With both stages full, in_ready=0.
- Stage 1:
  - Register sign = in_data[NBITS-1].
  - zero = (in_data==0); inf = (in_data=={1,0...0}).
  - abs = sign ? two's complement of in_data : in_data.
- Stage 2, regime:
  - r = abs[NBITS-2]. m = length of the leading run of bits equal to r in abs[NBITS-2:0], range 1..NBITS-1.
  - k = r ? m-1 : -m.
- Stage 2, remaining fields:
  - rem = abs[NBITS-2:0] << (m+1), zero-filled, truncated to NBITS-1 bits.
  - exponent = rem[NBITS-2 -: ES].
  - fraction = rem[NBITS-2-ES -: FBITS].
  - If the run consumes all bits (m=NBITS-1), exponent=0 and fraction=0.
- Scale: scale = (k << ES) + exponent, signed 8 bit. The range for 32/2 is −120..+120, with no overflow possible.
- Special cases:
  - When zero or inf, out_sign/out_scale/out_exponent/out_fraction are all driven 0. Only the flag is set.
  - The inf word 0x80000000 is reported with out_sign=0.
- Reset mid-operation: in-flight words are discarded. No output is produced for them after reset deasserts.

Test Plan:
- 0x40000000 -> sign0 scale0 exp0 frac0 zero0 inf0, out_valid exactly 2 cycles after in transfer.
- 0x4C000000 (3.0) -> sign0 scale1 exp1 frac=0x4000000. 0xC0000000 (−1.0) -> sign1 scale0 exp0 frac0.
- 0x7FFFFFFF -> scale+120 exp0 frac0. 0x00000001 -> scale−120 exp0 frac0. 0x00000000 -> zero1, rest 0. 0x80000000 -> inf1, sign0, rest 0.
- Back-to-back stream of 8 words with out_ready=1 -> 8 results on 8 consecutive cycles, in order, in_ready constant 1.
- Stream of 4 words, out_ready=0 for 5 cycles after first result -> outputs held stable, in_ready=0 once both stages full, all 4 results delivered in order after release, none lost or duplicated.
- Assert reset for 1 cycle with 2 words in flight -> out_valid=0 and in_ready=1 immediately (async), no stale result appears afterward; a new word 0x48000000 then decodes to scale1 exp1 frac0.
